divide_clk_multi: RTL and testbench
===================================

Name: divide_clk_multi

Overview:
- Multi-channel programmable clock/PWM divider. Successor to the single-channel fixed divider.
- CH independent channels. Each has its own period M and high threshold N, loadable at run time through a shadow-register write port.
- Updates are glitch-free: new values apply only at the period wrap.
- Drives LED/buzzer/scan timing and slow-tick enables for the rest of the design from the single system clock.

Parameters:
- CH, 4, number of channels (1..16).
- WIDTH, 24, counter / M / N width in bits.
- M_DEF, 1_000_000, reset period of every channel (cycles).
- N_DEF, 500_000, reset high threshold of every channel.

Ports:
- clkI  in  1  system clock, all logic on rising edge.
- rstN  in  1  asynchronous active-low reset.
- en  in  CH  per-channel synchronous run enable.
- cfgWr  in  1  write strobe for shadow config, one cycle.
- cfgCh  in  $clog2(CH) (min 1)  target channel of write.
- cfgM  in  WIDTH  new period.
- cfgN  in  WIDTH  new high threshold.
- clkO  out  CH  divided clock / PWM output, registered.
- wrapO  out  CH  one-cycle pulse per completed period, registered.
- pendO  out  CH  shadow config written but not yet applied.

Behaviour:
- Per-channel state:
  - counter r (WIDTH, cycles 1..Mact)
  - active Mact/Nact
  - shadow Msh/Nsh
  - pending bit
- Reset (rstN=0, async): r=1, Mact=Msh=M_DEF, Nact=Nsh=N_DEF, clkO=0, wrapO=0, pendO=0.
- Clamp: any M value of 0 is treated as 1, both on write and at use.
- Channel running (en[i]=1), each edge:
  - clkO[i] <= (r>=Nact) || (r==Mact).
  - wrapO[i] <= (r==Mact).
  - r <= (r==Mact) ? 1 : r+1.
  - Output lags the counter by one cycle. The period is exactly Mact cycles.
  - High time is Mact-Nact+1 cycles when 1<=Nact<=Mact.
  - Nact=0 gives constant high.
  - Nact>Mact gives a 1-cycle high pulse per period.
  - Mact=1 gives constant high and wrapO high every cycle.
- Apply rule: on the edge where r==Mact and pending=1, Mact<=Msh, Nact<=Nsh, pending<=0. The new period starts with r=1.
- Config write: cfgWr=1 loads Msh/Nsh of channel cfgCh and sets pending=1 on the same edge.
  - Write in the wrap cycle: the shadow value held before the edge is applied, and the new write stays pending for the next wrap.
  - Write while pending: overwrites the shadow (last write wins). No error flag.
  - cfgCh>=CH: write ignored.
- Channel stopped (en[i]=0): r<=1, clkO<=0, wrapO<=0. A pending shadow is applied immediately, so pendO clears the next cycle.
- en rising: the first counted cycle has r=1, and clkO reflects r=1 one cycle later.
- Reset mid-period: everything returns to reset values at once, and shadow writes are lost.
- Channels never interact, except through the shared cfg port and the optional sync.

Optional Feature:
- Macro DIVCLK_SYNC_EN.
- Defined: adds input port syncI (1 bit). When syncI=1 at an edge:
  - every channel with en=1 gets r<=1, clkO<=0, wrapO<=0, and applies any pending shadow.
  - Channels are then phase-aligned.
  - syncI has priority over a wrap in the same cycle.
- Undefined: no syncI port. Channels are aligned only by reset or en toggling.

Test Plan:
- Reset then en=1 on ch0 with M=4,N=3 (via write while disabled) -> clkO[0] repeats 0,0,1,1; wrapO[0] pulses every 4 cycles; pendO stays 0 after enable.
- Running ch1 M=10,N=6, write M=4,N=2 mid-period -> pendO[1]=1 until the current 10-cycle period ends; next period is 4 cycles with pattern 0,1,1,1; no short or long glitch period.
- Boundary writes:
  - N=0 -> constant 1.
  - N=12,M=8 -> single 1 per 8 cycles.
  - M=0 -> treated as 1, constant 1, wrapO constant 1.
- Write in the exact wrap cycle of ch2 -> old shadow applied this wrap; new value applied at the following wrap; two writes before a wrap -> only the last one takes effect.
- Assert rstN low mid-period with pending config -> clkO, wrapO, pendO = 0 asynchronously; after release, outputs follow M_DEF/N_DEF.
- (DIVCLK_SYNC_EN) channels at arbitrary phases, pulse syncI -> all enabled channels restart with r=1 on the same edge; rising clkO edges coincide for equal M/N.

Source files
------------

// File: rtl/divide_clk_multi.sv
// divide_clk_multi: CH-channel programmable clock/PWM divider with glitch-free shadow config; optional syncI via DIVCLK_SYNC_EN
module divide_clk_multi #(
  parameter int CH = 4,
  parameter int WIDTH = 24,
  parameter int M_DEF = 1_000_000,
  parameter int N_DEF = 500_000,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clkI,
  input  logic             rstN,
  input  logic [CH-1:0]    en,
`ifdef DIVCLK_SYNC_EN
  input  logic             syncI,
`endif
  input  logic             cfgWr,
  input  logic [CW-1:0]    cfgCh,
  input  logic [WIDTH-1:0] cfgM,
  input  logic [WIDTH-1:0] cfgN,
  output logic [CH-1:0]    clkO,
  output logic [CH-1:0]    wrapO,
  output logic [CH-1:0]    pendO
);
  localparam int M_CLAMP = (M_DEF == 0) ? 1 : M_DEF;
  logic w_sync;
  logic [WIDTH-1:0] w_cfg_m;
`ifdef DIVCLK_SYNC_EN
  assign w_sync = syncI;
`else
  assign w_sync = 1'b0;
`endif
  assign w_cfg_m = (cfgM == '0) ? WIDTH'(1) : cfgM;
  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [WIDTH-1:0] r_cnt, r_mact, r_nact, r_msh, r_nsh;
    logic r_pend, r_clk, r_wrap;
    logic [WIDTH-1:0] w_m;
    logic w_wr, w_wrap, w_restart, w_apply;
    assign w_m = (r_mact == '0) ? WIDTH'(1) : r_mact;
    assign w_wr = cfgWr && (cfgCh == CW'(g));
    assign w_wrap = (r_cnt == w_m);
    // a stopped channel and a sync pulse both force a fresh period starting at r=1
    assign w_restart = !en[g] || w_sync;
    // shadow values only move to active at a period boundary, so output never glitches
    assign w_apply = r_pend && (w_restart || w_wrap);
    // per-channel counter, registered outputs and shadow/active config
    always_ff @(posedge clkI or negedge rstN) begin
      if (!rstN) begin
        r_cnt  <= WIDTH'(1);
        r_mact <= WIDTH'(M_CLAMP);
        r_msh  <= WIDTH'(M_CLAMP);
        r_nact <= WIDTH'(N_DEF);
        r_nsh  <= WIDTH'(N_DEF);
        r_pend <= 1'b0;
        r_clk  <= 1'b0;
        r_wrap <= 1'b0;
      end else begin
        r_cnt  <= (w_restart || w_wrap) ? WIDTH'(1) : r_cnt + WIDTH'(1);
        r_clk  <= !w_restart && ((r_cnt >= r_nact) || w_wrap);
        r_wrap <= !w_restart && w_wrap;
        if (w_apply) begin
          r_mact <= r_msh;
          r_nact <= r_nsh;
        end
        if (w_wr) begin
          r_msh <= w_cfg_m;
          r_nsh <= cfgN;
        end
        r_pend <= w_wr || (r_pend && !w_apply);
      end
    end
    assign clkO[g]  = r_clk;
    assign wrapO[g] = r_wrap;
    assign pendO[g] = r_pend;
  end
endmodule

// File: tb/tb_divide_clk_multi.sv
// tb_divide_clk_multi: scoreboard bench, stimulus queues expected outputs per edge, monitor checks at negedge
module tb_divide_clk_multi;
  logic clkI = 1'b0;
  logic rstN = 1'b0;
  logic [3:0] en = '0;
  logic cfgWr = 1'b0;
  logic [1:0] cfgCh = '0;
  logic [7:0] cfgM = '0;
  logic [7:0] cfgN = '0;
  logic [3:0] clkO, wrapO, pendO;
`ifdef DIVCLK_SYNC_EN
  logic syncI = 1'b0;
`endif
  typedef struct {
    string nm;
    logic [3:0] mk, c, w, p;
  } rec_t;
  rec_t q[$];
  int n_tests = 0;
  int n_fail = 0;
  event async_smp;

  divide_clk_multi #(.CH(4), .WIDTH(8), .M_DEF(6), .N_DEF(4)) dut (
    .clkI(clkI), .rstN(rstN), .en(en),
`ifdef DIVCLK_SYNC_EN
    .syncI(syncI),
`endif
    .cfgWr(cfgWr), .cfgCh(cfgCh), .cfgM(cfgM), .cfgN(cfgN),
    .clkO(clkO), .wrapO(wrapO), .pendO(pendO)
  );

  always #5 clkI = ~clkI;

  // queue the outputs expected right after the coming rising edge
  task automatic cyc(input string nm, input logic [3:0] mk, input logic [3:0] c, input logic [3:0] w, input logic [3:0] p);
    rec_t r;
    @(posedge clkI);
    r.nm = nm; r.mk = mk; r.c = c; r.w = w; r.p = p;
    q.push_back(r);
    #1;
  endtask

  task automatic run_seq(input string nm, input int ch, input logic [3:0] mk, input string c, input string w, input string p,
                         input int wa, input logic [7:0] ma, input logic [7:0] na,
                         input int wb, input logic [7:0] mb, input logic [7:0] nb);
    en[ch] = 1'b1;
    for (int i = 0; i < c.len(); i++) begin
      cfgWr = (i == wa) || (i == wb);
      cfgCh = ch[1:0];
      cfgM = (i == wb) ? mb : ma;
      cfgN = (i == wb) ? nb : na;
      cyc(nm, mk, mk & {4{c[i] == "1"}}, mk & {4{w[i] == "1"}}, mk & {4{p[i] == "1"}});
    end
    cfgWr = 1'b0;
  endtask

  task automatic cfg_dis(input string nm, input int ch, input logic [7:0] m, input logic [7:0] n);
    logic [3:0] b;
    b = 4'(1 << ch);
    en[ch] = 1'b0;
    cfgWr = 1'b1; cfgCh = ch[1:0]; cfgM = m; cfgN = n;
    cyc(nm, b, 4'h0, 4'h0, b);
    cfgWr = 1'b0;
    cyc(nm, b, 4'h0, 4'h0, 4'h0);
  endtask

  // monitor: pops one expectation per sample point and compares the masked outputs
  initial begin
    rec_t r;
    forever begin
      @(negedge clkI or async_smp);
      if (q.size() != 0) begin
        r = q.pop_front();
        if (r.mk != 4'h0) begin
          n_tests++;
          if (((clkO & r.mk) != r.c) || ((wrapO & r.mk) != r.w) || ((pendO & r.mk) != r.p)) begin
            n_fail++;
            $display("FAIL %s: clkO=%b wrapO=%b pendO=%b expected clkO=%b wrapO=%b pendO=%b (mask %b) at %0t",
                     r.nm, clkO & r.mk, wrapO & r.mk, pendO & r.mk, r.c, r.w, r.p, r.mk, $time);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    cyc("reset", 4'hF, 4'h0, 4'h0, 4'h0);
    cyc("reset", 4'hF, 4'h0, 4'h0, 4'h0);
    rstN = 1'b1;
    cfg_dis("ch0_cfg", 0, 8'd4, 8'd3);
    run_seq("ch0_m4n3", 0, 4'h1, "00110011", "00010001", "00000000", -1, 0, 0, -1, 0, 0);
    cfg_dis("ch1_cfg", 1, 8'd10, 8'd6);
    run_seq("ch1_midwrite", 1, 4'h2, "0000011111011101", "0000000001000100", "0001111110000000", 3, 8'd4, 8'd2, -1, 0, 0);
    cfg_dis("ch1_n0_cfg", 1, 8'd4, 8'd0);
    run_seq("ch1_n0", 1, 4'h2, "11111111", "00010001", "00000000", -1, 0, 0, -1, 0, 0);
    cfg_dis("ch2_ngtm_cfg", 2, 8'd8, 8'd12);
    run_seq("ch2_ngtm", 2, 4'h4, "0000000100000001", "0000000100000001", "0000000000000000", -1, 0, 0, -1, 0, 0);
    cfg_dis("ch3_m0_cfg", 3, 8'd0, 8'd5);
    run_seq("ch3_m0", 3, 4'h8, "111111", "111111", "000000", -1, 0, 0, -1, 0, 0);
    cfg_dis("ch2_cfg", 2, 8'd4, 8'd3);
    run_seq("ch2_wrapwrite", 2, 4'h4, "0011000011011011", "0001000001001001", "0111111110000000", 1, 8'd6, 8'd5, 3, 8'd3, 8'd2);
    run_seq("ch2_lastwins", 2, 4'h4, "0110001100", "0010000100", "1100000000", 0, 8'd7, 8'd1, 1, 8'd5, 8'd4);
    run_seq("ch2_pend", 2, 4'h4, "01", "00", "11", 0, 8'd9, 8'd9, -1, 0, 0);
    @(negedge clkI);
    #1 rstN = 1'b0;
    #1 q.push_back('{nm: "async_rst", mk: 4'hF, c: 4'h0, w: 4'h0, p: 4'h0});
    -> async_smp;
    cyc("rst_hold", 4'hF, 4'h0, 4'h0, 4'h0);
    rstN = 1'b1;
    en = 4'hF;
    run_seq("defaults", 0, 4'hF, "000111000111", "000001000001", "000000000000", -1, 0, 0, -1, 0, 0);
`ifdef DIVCLK_SYNC_EN
    en = 4'hE;
    cyc("desync", 4'h0, 4'h0, 4'h0, 4'h0);
    en = 4'hF;
    cyc("desync", 4'h0, 4'h0, 4'h0, 4'h0);
    cyc("desync", 4'h0, 4'h0, 4'h0, 4'h0);
    syncI = 1'b1;
    cyc("sync", 4'hF, 4'h0, 4'h0, 4'h0);
    syncI = 1'b0;
    run_seq("aligned", 0, 4'hF, "000111", "000001", "000000", -1, 0, 0, -1, 0, 0);
`endif
    @(negedge clkI);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
